mem_interface_unit: RTL
=======================

Name: mem_interface_unit

Overview:
- Memory-side responder for the core's L1 instruction-cache and data-cache miss/writeback requests.
- Accepts line-fill (I and D) and line-writeback (D only) requests.
- Arbitrates the two caches; I-cache has priority by default.
- Runs each line as a word-serial burst on a simple ready-handshake memory bus, then acknowledges the requesting cache.
- Sits between the cache modules inside the core and the external memory/system bus.

Parameters:
- WORD_LENGTH, 32, data and address width in bits.
- LINE_WORDS, 4, words per cache line; power of two, 2..16.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- iReq  in  1  I-cache line-fill request; held until iAck
- iAdr  in  WORD_LENGTH  I-cache miss byte address
- iRData  out  WORD_LENGTH  fill data word
- iRValid  out  1  iRData valid this cycle
- iAck  out  1  one-cycle pulse: I transaction complete
- dReq  in  1  D-cache request; held until dAck
- dWr  in  1  1 = writeback, 0 = fill; stable while dReq
- dAdr  in  WORD_LENGTH  D-cache byte address
- dWData  in  WORD_LENGTH  writeback word for index dWIdx; combinational from cache
- dWIdx  out  log2(LINE_WORDS)  current writeback word index
- dRData  out  WORD_LENGTH  fill data word
- dRValid  out  1  dRData valid this cycle
- dAck  out  1  one-cycle pulse: D transaction complete
- memReq  out  1  beat request to memory
- memWr  out  1  beat is a write
- memAdr  out  WORD_LENGTH  word-aligned beat byte address
- memWData  out  WORD_LENGTH  write beat data
- memRData  in  WORD_LENGTH  read beat data; valid when memRdy
- memRdy  in  1  memory completes the current beat this cycle

Behaviour:
- Reset state: FSM IDLE, beat counter 0. All outputs are 0.
- States:
  - IDLE: if iReq, go to I_RD. Else if dReq && !dWr, go to D_RD. Else if dReq && dWr, go to D_WR.
  - I_RD, D_RD, D_WR: one beat per memRdy.
  - DONE: lasts one cycle, then unconditionally returns to IDLE.
- Line base = requester address with low log2(LINE_WORDS)+2 bits cleared. The base is latched on grant; later address changes are ignored.
- Beat n (n = 0..LINE_WORDS-1):
  - memReq = 1.
  - memAdr = base + 4n.
  - memWr = 1 only in D_WR.
  - In D_WR: memWData = dWData and dWIdx = n.
- A beat completes at an edge with memReq && memRdy; the counter then increments. memReq stays high across beats, so back-to-back beats are possible when memRdy is held high.
- Read beats: memRData is registered into xRData, with xRValid = 1 for exactly the next cycle. Word order is ascending from the base.
- The last beat's completion moves the FSM to DONE. In DONE, xAck = 1; for reads this is the same cycle as the last xRValid. memReq = 0 in DONE and IDLE.
- Minimum transaction = LINE_WORDS + 2 cycles (grant edge, beats, DONE). At least one IDLE cycle separates transactions.
- A requester must drop xReq in the cycle after xAck. Since IDLE samples xReq, a request still held at that point is treated as a new request.
- Requests raised mid-transaction wait, with no loss.
- Simultaneous iReq and dReq in IDLE: the I-cache wins. D is served next if dReq is still held.
- Counter wrap: the counter resets to 0 on entry to DONE.
- rst mid-burst: at that edge, return to IDLE with all outputs 0. No ack is issued, and the partial line is abandoned. Memory must tolerate the dropped memReq.
- memRdy while memReq = 0 is ignored.

Optional Feature:
- Macro MIU_ROUND_ROBIN_EN.
- Defined: a 1-bit lastGrant register, reset to D.
  - On simultaneous iReq/dReq in IDLE, grant the cache not served last.
  - Single requests are granted as usual.
  - lastGrant updates on every grant.
- Undefined: fixed I-over-D priority; no lastGrant register.

Test Plan:
- I-fill, dReq=0:
  - Stimulus: iReq=1, iAdr=0x0000_1234, memRdy=1 constant, memRData = address-based pattern.
  - Required: memAdr = 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles.
  - Required: iRValid on 4 consecutive cycles with matching data, iAck with the last word, 6 cycles total.
- D-writeback with stalls:
  - Stimulus: dReq=1, dWr=1, dAdr=0x8000_0010, memRdy toggling 0/1.
  - Required: memWr=1, dWIdx steps 0..3 only after ready beats, memWData equals the cache word for each index, dAck one cycle after the 4th ready.
- Simultaneous iReq, dReq (fill, dAdr=0x40):
  - Macro off: I line served first, then D after 1 IDLE cycle; no dRValid during the I burst.
  - Macro on, lastGrant=I: D served first.
- Reset mid-op: assert rst after beat 2 of an I-fill. Required: next cycle memReq=0, iAck never pulses, state IDLE; a new iReq completes normally.
- Held request: keep iReq high after iAck. Required: a second identical fill begins after one IDLE cycle.
- Idle noise: memRdy=1 with no requests for 10 cycles. Required: memReq, xRValid and xAck stay 0.

Source files
------------

// File: rtl/mem_interface_unit.sv
// Word-serial line-fill / writeback responder between the L1 I/D caches and a ready-handshake memory bus.
// Optional MIU_ROUND_ROBIN_EN: alternate grants between I and D on simultaneous requests.
module mem_interface_unit #(
    parameter int WORD_LENGTH = 32,
    parameter int LINE_WORDS  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iReq,
    input  logic [WORD_LENGTH-1:0]         iAdr,
    output logic [WORD_LENGTH-1:0]         iRData,
    output logic                           iRValid,
    output logic                           iAck,
    input  logic                           dReq,
    input  logic                           dWr,
    input  logic [WORD_LENGTH-1:0]         dAdr,
    input  logic [WORD_LENGTH-1:0]         dWData,
    output logic [$clog2(LINE_WORDS)-1:0]  dWIdx,
    output logic [WORD_LENGTH-1:0]         dRData,
    output logic                           dRValid,
    output logic                           dAck,
    output logic                           memReq,
    output logic                           memWr,
    output logic [WORD_LENGTH-1:0]         memAdr,
    output logic [WORD_LENGTH-1:0]         memWData,
    input  logic [WORD_LENGTH-1:0]         memRData,
    input  logic                           memRdy
);

    localparam int CW = $clog2(LINE_WORDS);
    localparam logic [WORD_LENGTH-1:0] LINE_MASK = ~WORD_LENGTH'(LINE_WORDS * 4 - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} stateT;

    stateT                  state;
    stateT                  nextState;
    logic [CW-1:0]          cnt;
    logic [WORD_LENGTH-1:0] base;
    logic                   ownerD;
    logic                   grantI;
    logic                   grantD;
    logic                   beating;
    logic                   lastBeat;

    assign beating  = (state == I_RD) || (state == D_RD) || (state == D_WR);
    assign lastBeat = (cnt == LAST_BEAT);

`ifdef MIU_ROUND_ROBIN_EN
    // lastGrant = 1 means D was served last, so I wins the next tie.
    logic lastGrant;

    always_comb begin
        grantI = iReq && (!dReq || lastGrant);
        grantD = dReq && !grantI;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant <= 1'b1;
        end else if (state == IDLE && (grantI || grantD)) begin
            lastGrant <= grantD;
        end
    end
`else
    always_comb begin
        grantI = iReq;
        grantD = dReq && !iReq;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (grantI) begin
                    nextState = I_RD;
                end else if (grantD) begin
                    nextState = dWr ? D_WR : D_RD;
                end
            end
            I_RD, D_RD, D_WR: begin
                if (memRdy && lastBeat) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Line base and owner are captured at grant so address changes during the burst are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            base    <= '0;
            ownerD  <= 1'b0;
            iRValid <= 1'b0;
            dRValid <= 1'b0;
            iRData  <= '0;
            dRData  <= '0;
        end else begin
            iRValid <= 1'b0;
            dRValid <= 1'b0;
            if (state == IDLE && (grantI || grantD)) begin
                base   <= (grantI ? iAdr : dAdr) & LINE_MASK;
                ownerD <= !grantI;
                cnt    <= '0;
            end
            if (beating && memRdy) begin
                cnt <= lastBeat ? '0 : cnt + 1'b1;
                if (state == I_RD) begin
                    iRValid <= 1'b1;
                    iRData  <= memRData;
                end
                if (state == D_RD) begin
                    dRValid <= 1'b1;
                    dRData  <= memRData;
                end
            end
        end
    end

    always_comb begin
        memReq   = beating;
        memWr    = (state == D_WR);
        memAdr   = '0;
        memWData = '0;
        dWIdx    = '0;
        iAck     = (state == DONE) && !ownerD;
        dAck     = (state == DONE) && ownerD;
        if (beating) begin
            memAdr = base + {{(WORD_LENGTH - CW - 2){1'b0}}, cnt, 2'b00};
        end
        if (state == D_WR) begin
            memWData = dWData;
            dWIdx    = cnt;
        end
    end

endmodule
